// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Package : btn_pkg
// Shared state encoding, button indices and helpers for the pushbutton
// conditioner.
// Rev     : 1.0
// ============================================================================
package btn_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Interface : button_conditioner_if
// Raw button inputs and conditioned level/pulse/move outputs, one bit per
// button.
// Rev       : 1.0
// ============================================================================
interface button_conditioner_if;
  import btn_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_move;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_move
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_move
  );

endinterface
`default_nettype wire

// File: rtl/btn_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce_fsm
// One button: 2-FF synchroniser, debounce FSM, press/release pulses and
// hold-to-repeat strobe, all registered.
// Rev    : 1.0
// ============================================================================
module btn_debounce_fsm #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 1_666_667
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_btn_raw,
  output logic      o_level,
  output logic      o_press,
  output logic      o_release,
  output logic      o_move_pre
);
  import btn_pkg::*;

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int c_RPT_W = $clog2(btn_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RPT_W-1:0] c_RPT_DELAY  = c_RPT_W'(REPEAT_DELAY);
  localparam logic [c_RPT_W-1:0] c_RPT_PERIOD = c_RPT_W'(REPEAT_PERIOD);

  logic               r_meta, r_sync;
  btn_state_t         r_state, w_state_next;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [c_RPT_W-1:0] r_rpt, w_rpt_next, w_rpt_inc, w_rpt_target;
  logic               r_rep, w_rep_next;
  logic               r_level, w_level_next;
  logic               r_press, w_press_next;
  logic               r_release, w_release_next;
  logic               r_move, w_move_next;
  logic               w_cnt_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rpt     <= '0;
      r_rep     <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_move    <= 1'b0;
    end else begin
      r_meta    <= i_btn_raw;
      r_sync    <= r_meta;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rpt     <= w_rpt_next;
      r_rep     <= w_rep_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_move    <= w_move_next;
    end
  end

  assign w_cnt_done = (r_cnt == c_CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:        if (r_sync) w_state_next = DEB_PRESS;
      DEB_PRESS:   if (!r_sync) w_state_next = IDLE;
                   else if (w_cnt_done) w_state_next = HELD;
      HELD:        if (!r_sync) w_state_next = DEB_RELEASE;
      DEB_RELEASE: if (r_sync) w_state_next = HELD;
                   else if (w_cnt_done) w_state_next = IDLE;
      default:     w_state_next = IDLE;
    endcase
  end

  // rpt counts toward REPEAT_DELAY first, then toward REPEAT_PERIOD after each strobe
  always_comb begin
    w_cnt_inc      = w_cnt_done ? r_cnt : r_cnt + c_CNT_W'(1);
    w_rpt_inc      = (r_rpt == '1) ? r_rpt : r_rpt + c_RPT_W'(1);
    w_rpt_target   = r_rep ? c_RPT_PERIOD : c_RPT_DELAY;
    w_cnt_next     = r_cnt;
    w_rpt_next     = r_rpt;
    w_rep_next     = r_rep;
    w_level_next   = r_level;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_move_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync) w_cnt_next = c_CNT_W'(1);
      end
      DEB_PRESS: begin
        if (!r_sync) begin
          w_cnt_next = '0;
        end else if (w_cnt_done) begin
          w_cnt_next   = '0;
          w_rpt_next   = '0;
          w_rep_next   = 1'b0;
          w_level_next = 1'b1;
          w_press_next = 1'b1;
          w_move_next  = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      HELD: begin
        if (!r_sync) begin
          w_cnt_next = c_CNT_W'(1);
        end else if (w_rpt_inc >= w_rpt_target) begin
          w_rpt_next  = '0;
          w_rep_next  = 1'b1;
          w_move_next = 1'b1;
        end else begin
          w_rpt_next = w_rpt_inc;
        end
      end
      DEB_RELEASE: begin
        if (r_sync) begin
          w_cnt_next = '0;
        end else if (w_cnt_done) begin
          w_cnt_next     = '0;
          w_level_next   = 1'b0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: w_cnt_next = '0;
    endcase
  end

  assign o_level    = r_level;
  assign o_press    = r_press;
  assign o_release  = r_release;
  assign o_move_pre = r_move;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module : button_conditioner
// Conditions four raw pushbuttons into debounced levels, press/release pulses
// and opposite-direction-cancelled move strobes.
// Rev    : 1.0
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 1_666_667
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  button_conditioner_if.slave bus
);
  import btn_pkg::*;

  logic [NUM_BTN-1:0] w_level, w_press, w_release, w_move_pre, w_move_cancel;
  logic [NUM_BTN-1:0] r_level, r_press, r_release, r_move;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_btn_raw  (bus.btn_raw[g]),
      .o_level    (w_level[g]),
      .o_press    (w_press[g]),
      .o_release  (w_release[g]),
      .o_move_pre (w_move_pre[g])
    );
  end

  always_comb begin
    w_move_cancel = w_move_pre;
    if (w_move_pre[BTN_UP] && w_move_pre[BTN_DOWN]) begin
      w_move_cancel[BTN_UP]   = 1'b0;
      w_move_cancel[BTN_DOWN] = 1'b0;
    end
    if (w_move_pre[BTN_LEFT] && w_move_pre[BTN_RIGHT]) begin
      w_move_cancel[BTN_LEFT]  = 1'b0;
      w_move_cancel[BTN_RIGHT] = 1'b0;
    end
  end

  // level/press/release ride through the same stage as move to stay aligned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_move    <= '0;
    end else begin
      r_level   <= w_level;
      r_press   <= w_press;
      r_release <= w_release;
      r_move    <= w_move_cancel;
    end
  end

  assign bus.btn_level   = r_level;
  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;
  assign bus.btn_move    = r_move;

endmodule
`default_nettype wire
